// File: rtl/apb_master_ctrl.sv
// APB requester: turns one valid/ready command into a single SETUP+ACCESS transfer and
// returns read data / error status on a valid/ready response channel, with optional timeout.
module apb_master_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  // command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  // APB requester side
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSetup  = 2'd1;
  localparam logic [1:0] StAccess = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntLast);

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d  = StSetup;
          psel_d   = 1'b1;
          penable_d = 1'b0;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_write ? cmd_wdata : '0;
          cnt_d    = '0;
        end
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
      end
      StAccess: begin
        // PREADY wins over a timeout landing in the same cycle
        if (PREADY) begin
          state_d       = StResp;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          state_d       = StResp;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= StIdle;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cmd_ready   = (state_q == StIdle);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: directed and randomized transfers against a transfer-level
// model (wait states, timeout limit, error and data rules), plus a TIMEOUT=0 instance.
module tb_apb_master_ctrl;

  localparam int TMO = 16;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_valid0, cmd_write, rsp_ready;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata, PRDATA;
  logic        PREADY, PSLVERR;

  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE;
  logic [31:0] rsp_rdata, PWDATA;
  logic [7:0]  PADDR;

  logic        cmd_ready0, rsp_valid0, rsp_err0, rsp_timeout0, PSEL0, PENABLE0, PWRITE0;
  logic [31:0] rsp_rdata0, PWDATA0;
  logic [7:0]  PADDR0;

  int checks = 0;
  int errors = 0;

  // command presented by the source while the current transfer is still running
  bit          next_pending = 0;
  logic        nxt_write = 1'b0;
  logic [7:0]  nxt_addr = '0;
  logic [31:0] nxt_wdata = '0;

  always #5 PCLK = ~PCLK;

  apb_master_ctrl #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(TMO)) u_dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_master_ctrl #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(0)) u_dut0 (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0),
    .rsp_err(rsp_err0), .rsp_timeout(rsp_timeout0),
    .PSEL(PSEL0), .PENABLE(PENABLE0), .PWRITE(PWRITE0), .PADDR(PADDR0), .PWDATA(PWDATA0),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Starts at an IDLE-cycle negedge, ends at the IDLE-cycle negedge after the rsp handshake.
  task automatic xfer(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                      input int waits, input logic [31:0] rdata, input bit slverr,
                      input int rsp_delay);
    bit          to;
    int          exp_n;
    logic [31:0] exp_rd, exp_pw;
    to     = (waits + 1) > TMO;
    exp_n  = to ? TMO : waits + 1;
    exp_pw = wr ? wdata : 32'h0;
    exp_rd = (wr || to) ? 32'h0 : rdata;

    chk("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    rsp_ready = 1'b0; PREADY = 1'b0;
    @(negedge PCLK);
    cmd_valid = next_pending; cmd_write = nxt_write; cmd_addr = nxt_addr; cmd_wdata = nxt_wdata;
    chk("setup_psel_pen_rdy", {PSEL, PENABLE, cmd_ready}, 3'b100);
    chk("setup_cmd", {PWRITE, PADDR, PWDATA}, {wr, addr, exp_pw});

    for (int n = 1; n <= exp_n; n++) begin
      @(negedge PCLK);
      chk("acc_psel_pen_rsp", {PSEL, PENABLE, rsp_valid}, 3'b110);
      chk("acc_cmd_stable", {PWRITE, PADDR, PWDATA}, {wr, addr, exp_pw});
      if (n == waits + 1) begin
        PREADY = 1'b1; PRDATA = rdata; PSLVERR = slverr;
      end else begin
        // garbage data and error pulses outside the completing cycle must be ignored
        PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom_range(0, 1));
      end
    end

    @(negedge PCLK);
    PREADY = 1'b0; PSLVERR = 1'b0;
    for (int d = 0; d <= rsp_delay; d++) begin
      chk("rsp_fields", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata},
          {1'b1, to | slverr, to, exp_rd});
      chk("rsp_bus_quiet", {PSEL, PENABLE, cmd_ready}, 3'b000);
      if (d == rsp_delay) rsp_ready = 1'b1;
      @(negedge PCLK);
    end
    rsp_ready = 1'b0;
    chk("post_idle", {rsp_valid, cmd_ready, PSEL}, 3'b010);
    chk("post_hold", {PWRITE, PADDR, PWDATA}, {wr, addr, exp_pw});
  endtask

  initial begin
    bit          w;
    int          wt;
    logic [31:0] rd;

    PRESET = 1'b1; cmd_valid = 1'b0; cmd_valid0 = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    chk("reset_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 0);
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 0);
    chk("reset_rdy", {cmd_ready, cmd_ready0, rsp_valid0, PSEL0}, 4'b1100);

    xfer(1, 8'h04, 32'hDEADBEEF, 0, 32'h0, 0, 0);        // write, no wait
    xfer(0, 8'h10, 32'h11111111, 3, 32'h000000A5, 0, 0); // read, 3 wait states
    xfer(0, 8'h20, 32'h0, 2, 32'h5A5A5A5A, 1, 1);        // slave error
    xfer(0, 8'h24, 32'h0, 40, 32'h12345678, 0, 0);       // timeout after 16 ACCESS cycles
    xfer(1, 8'h28, 32'hCAFEF00D, 20, 32'h0, 1, 2);       // write timeout
    xfer(0, 8'h2C, 32'h0, TMO - 1, 32'h0BADF00D, 0, 0);  // PREADY on the last allowed cycle

    // backpressure with the next command held by the source
    next_pending = 1; nxt_write = 1'b1; nxt_addr = 8'h3C; nxt_wdata = 32'h12345678;
    xfer(0, 8'h30, 32'h0, 0, 32'h0000CAFE, 0, 5);
    next_pending = 0;
    xfer(1, 8'h3C, 32'h12345678, 0, 32'h0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      w  = 1'($urandom_range(0, 1));
      wt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 4));
      rd = $urandom;
      xfer(w, 8'($urandom), $urandom, wt, rd, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    // reset in the middle of ACCESS abandons the transfer
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h55; cmd_wdata = 32'hA5A5A5A5;
    PREADY = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    chk("rst_pre_access", {PSEL, PENABLE}, 2'b11);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    PREADY = 1'b1;
    chk("rst_apb_zero", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 0);
    chk("rst_rsp_zero", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      chk("rst_no_rsp", {rsp_valid, PSEL}, 2'b00);
    end
    PREADY = 1'b0;

    // TIMEOUT=0 instance never times out
    cmd_valid0 = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h44; cmd_wdata = 32'hFFFFFFFF;
    @(negedge PCLK);
    cmd_valid0 = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge PCLK);
      chk("nto_waiting", {PSEL0, PENABLE0, rsp_valid0, PWRITE0, PADDR0, PWDATA0},
          {3'b110, 1'b0, 8'h44, 32'h0});
      if (n == 100) begin PREADY = 1'b1; PRDATA = 32'h00000077; end
    end
    @(negedge PCLK);
    PREADY = 1'b0;
    chk("nto_rsp", {rsp_valid0, rsp_err0, rsp_timeout0, rsp_rdata0, PSEL0},
        {3'b100, 32'h00000077, 1'b0});
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    chk("nto_idle", {cmd_ready0, rsp_valid0, rsp_valid}, 3'b100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
